// File: rtl/conv_layer_ctrl_if.sv
// Control/status bundle between the convolution sequencer and its host.
// CONV_CTRL_ABORT_EN adds the i_abort request line.
interface conv_layer_ctrl_if;
    logic       i_start;
    logic       i_row_valid;
`ifdef CONV_CTRL_ABORT_EN
    logic       i_abort;
`endif
    logic [2:0] current_state;
    logic       o_busy;
    logic       o_done;
    logic [3:0] o_out_row;
    logic [1:0] o_kcol;

    modport master (
`ifdef CONV_CTRL_ABORT_EN
        output i_abort,
`endif
        output i_start, i_row_valid,
        input  current_state, o_busy, o_done, o_out_row, o_kcol
    );

    modport slave (
`ifdef CONV_CTRL_ABORT_EN
        input  i_abort,
`endif
        input  i_start, i_row_valid,
        output current_state, o_busy, o_done, o_out_row, o_kcol
    );
endinterface

// File: rtl/conv_layer_ctrl.sv
// Stage sequencer for one convolution layer: preload, three kernel rows, bias, row load.
// Optional macro CONV_CTRL_ABORT_EN enables the i_abort request.
//
// state   | meaning
// INIT    | clear counters, one cycle
// PRELOAD | fill weight cache, KERNEL_SIZE cycles
// ROW_0-2 | one kernel row each, o_kcol walks 0..KERNEL_SIZE-1
// BIAS    | add bias, one cycle, then LOAD or IDLE
// LOAD    | wait for next input row from the image buffer
// IDLE    | waiting for i_start
module conv_layer_ctrl #(
    parameter int KERNEL_SIZE = 3,
    parameter int IMAGE_SIZE  = 8,
    parameter int ARRAY_SIZE  = 6
) (
    input  logic               clk,
    input  logic               rst_n,
    conv_layer_ctrl_if.slave   bus
);

    typedef enum logic [2:0] {
        INIT    = 3'd0,
        PRELOAD = 3'd1,
        ROW_0   = 3'd2,
        ROW_1   = 3'd3,
        ROW_2   = 3'd4,
        BIAS    = 3'd5,
        LOAD    = 3'd6,
        IDLE    = 3'd7
    } state_t;

    localparam int TW = $clog2(KERNEL_SIZE + 1);
    localparam int VALID_ROWS = IMAGE_SIZE - KERNEL_SIZE + 1;
    // Never step past the last row the image can actually produce.
    localparam int ROWS = (ARRAY_SIZE < VALID_ROWS) ? ARRAY_SIZE : VALID_ROWS;
    localparam logic [3:0]    LAST_ROW   = 4'(ROWS - 1);
    localparam logic [1:0]    KCOL_LAST  = 2'(KERNEL_SIZE - 1);
    localparam logic [TW-1:0] PRELOAD_TC = TW'(KERNEL_SIZE - 1);

    state_t        state;
    logic          busy;
    logic          done;
    logic [3:0]    out_row;
    logic [1:0]    kcol;
    logic [TW-1:0] tmr;

    assign bus.current_state = state;
    assign bus.o_busy        = busy;
    assign bus.o_done        = done;
    assign bus.o_out_row     = out_row;
    assign bus.o_kcol        = kcol;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            out_row <= '0;
            kcol    <= '0;
            tmr     <= '0;
        end else begin
            done <= 1'b0;
`ifdef CONV_CTRL_ABORT_EN
            if (bus.i_abort) begin
                state   <= IDLE;
                busy    <= 1'b0;
                out_row <= '0;
                kcol    <= '0;
                tmr     <= '0;
            end else
`endif
            case (state)
                IDLE: begin
                    if (bus.i_start) begin
                        state   <= INIT;
                        busy    <= 1'b1;
                        out_row <= '0;
                        kcol    <= '0;
                    end
                end
                INIT: begin
                    state   <= PRELOAD;
                    tmr     <= PRELOAD_TC;
                    out_row <= '0;
                    kcol    <= '0;
                end
                PRELOAD: begin
                    if (tmr == '0) begin
                        state <= ROW_0;
                    end else begin
                        tmr <= tmr - 1'b1;
                    end
                end
                ROW_0, ROW_1, ROW_2: begin
                    if (kcol == KCOL_LAST) begin
                        kcol  <= '0;
                        state <= (state == ROW_0) ? ROW_1 :
                                 (state == ROW_1) ? ROW_2 : BIAS;
                    end else begin
                        kcol <= kcol + 2'd1;
                    end
                end
                BIAS: begin
                    if (out_row == LAST_ROW) begin
                        state   <= IDLE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        out_row <= '0;
                    end else begin
                        state <= LOAD;
                    end
                end
                LOAD: begin
                    if (bus.i_row_valid) begin
                        state   <= ROW_0;
                        out_row <= out_row + 4'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
